// File: rtl/rv_net_arbiter_pkg.sv
// Shared types and constants for the rv_net arbiter and later net switches.
// Imported by the interface, the round-robin picker and the arbiter top.
package rv_net_pkg;

   localparam int NET_DAT_W = 8;

   // Header byte offsets within a packet: DST, SZ, then SZ+1 body bytes.
   localparam int HDR_DST = 0;
   localparam int HDR_SZ  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DST  = 2'b01,
      SZ   = 2'b10,
      BODY = 2'b11
   } arb_state_e;

endpackage

// File: rtl/rv_net_arbiter_if.sv
// Ready/valid bundle between N_REQ requesters, the arbiter and the upstream net link.
// The slave modport is the arbiter's view; master is the environment's view.
interface rv_net_if #(
   parameter int N_REQ = 2
);
   import rv_net_pkg::*;

   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0]           req_ready;
   logic [NET_DAT_W*N_REQ-1:0] req_dat;
   logic                       neto_valid;
   logic                       neto_ready;
   logic [NET_DAT_W-1:0]       neto_dat;

   modport master (
      output req_valid,
      output req_dat,
      output neto_ready,
      input  req_ready,
      input  neto_valid,
      input  neto_dat
   );

   modport slave (
      input  req_valid,
      input  req_dat,
      input  neto_ready,
      output req_ready,
      output neto_valid,
      output neto_dat
   );

endinterface

// File: rtl/rv_net_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from i_last+1,
// wrapping to index 0. Shared with the net switches that build on this arbiter.
module rv_rr_pick #(
   parameter  int N_REQ = 2,
   localparam int GNT_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [GNT_W-1:0] i_last,
   output logic             o_found,
   output logic [GNT_W-1:0] o_gnt
);

   logic [N_REQ-1:0] w_mask;
   logic [N_REQ-1:0] w_req_hi;
   logic             w_hit_hi;

   // Requests strictly above the last winner get first look; otherwise wrap.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_mask[i] = (i > int'(i_last));
      end
   end

   assign w_req_hi = i_req & w_mask;
   assign w_hit_hi = |w_req_hi;
   assign o_found  = |i_req;

   always_comb begin
      o_gnt = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_hit_hi ? w_req_hi[i] : i_req[i]) begin
            o_gnt = GNT_W'(i);
         end
      end
   end

endmodule

// File: rtl/rv_net_arbiter.sv
// Packet-granular round-robin arbiter merging N_REQ ready/valid byte streams onto one net link.
// Optional macro RV_NET_ARB_OUTREG_EN puts a 2-entry skid buffer on the neto_ output path.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick next requester round-robin, no byte moves
// DST   | granted; waiting for the destination header byte
// SZ    | waiting for the size byte; it loads the body down-counter
// BODY  | forwarding body bytes; release after the byte seen at rem==0
module rv_net_arbiter
   import rv_net_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int GNT_W = $clog2(N_REQ)
) (
   input  logic             uclock,
   input  logic             reset,
   rv_net_if.slave          net,
   input  logic [N_REQ-1:0] hreq_i,
   output logic             hreq_o,
   output logic [GNT_W-1:0] gnt_o,
   output logic             busy_o
);

   arb_state_e           r_state;
   arb_state_e           w_state_nxt;
   logic [GNT_W-1:0]     r_gnt;
   logic [GNT_W-1:0]     w_gnt_nxt;
   logic [GNT_W-1:0]     r_last;
   logic [GNT_W-1:0]     w_last_nxt;
   logic [NET_DAT_W-1:0] r_rem;
   logic [NET_DAT_W-1:0] w_rem_nxt;
   logic                 r_hreq;

   logic                 w_found;
   logic [GNT_W-1:0]     w_pick;
   logic                 w_active;
   logic                 w_sel_valid;
   logic [NET_DAT_W-1:0] w_sel_dat;
   logic                 w_up_ready;
   logic                 w_xfer;

   rv_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .i_req   (net.req_valid),
      .i_last  (r_last),
      .o_found (w_found),
      .o_gnt   (w_pick)
   );

   assign w_active = (r_state != IDLE);

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_dat   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_gnt == GNT_W'(i)) begin
            w_sel_valid = net.req_valid[i];
            w_sel_dat   = net.req_dat[NET_DAT_W*i +: NET_DAT_W];
         end
      end
   end

   // Only the granted requester ever sees ready; it is held for the whole packet.
   always_comb begin
      net.req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_active && (r_gnt == GNT_W'(i))) begin
            net.req_ready[i] = w_up_ready;
         end
      end
   end

   // Packet length is counted on the requester side of any output buffering.
   assign w_xfer = w_active && w_sel_valid && w_up_ready;

`ifdef RV_NET_ARB_OUTREG_EN
   logic [NET_DAT_W-1:0] r_buf [2];
   logic [1:0]           r_cnt;
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic                 w_push;
   logic                 w_pop;

   assign w_up_ready     = (r_cnt != 2'd2);
   assign w_push         = w_xfer;
   assign w_pop          = net.neto_valid && net.neto_ready;
   assign net.neto_valid = (r_cnt != 2'd0);
   assign net.neto_dat   = r_buf[r_rd_ptr];

   always_ff @(posedge uclock) begin
      if (reset) begin
         r_cnt    <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge uclock) begin
      if (w_push) begin
         r_buf[r_wr_ptr] <= w_sel_dat;
      end
   end
`else
   assign w_up_ready     = net.neto_ready;
   assign net.neto_valid = w_active && w_sel_valid;
   assign net.neto_dat   = w_active ? w_sel_dat : '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last;
      w_rem_nxt   = r_rem;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               w_gnt_nxt   = w_pick;
               w_state_nxt = DST;
            end
         end
         DST: begin
            if (w_xfer) begin
               w_state_nxt = SZ;
            end
         end
         SZ: begin
            if (w_xfer) begin
               w_rem_nxt   = w_sel_dat;
               w_state_nxt = BODY;
            end
         end
         BODY: begin
            if (w_xfer) begin
               if (r_rem == '0) begin
                  w_last_nxt  = r_gnt;
                  w_state_nxt = IDLE;
               end else begin
                  w_rem_nxt = r_rem - 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // After reset requester 0 wins first because the search starts at last+1.
   always_ff @(posedge uclock) begin
      if (reset) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_last  <= GNT_W'(N_REQ - 1);
         r_rem   <= '0;
         r_hreq  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_last  <= w_last_nxt;
         r_rem   <= w_rem_nxt;
         r_hreq  <= (|hreq_i) | (|net.req_valid) | w_active;
      end
   end

   assign hreq_o = r_hreq;
   assign gnt_o  = r_gnt;
   assign busy_o = w_active;

endmodule

// File: tb/tb_rv_net_arbiter.sv
// Directed bench for rv_net_arbiter (default build): cycle table plus packet-level sequences.
module tb_rv_net_arbiter;
   import rv_net_pkg::*;

   localparam int N = 2;

   logic         uclock = 1'b0;
   logic         reset  = 1'b1;
   logic [N-1:0] hreq_i = '0;
   logic         hreq_o;
   logic [0:0]   gnt_o;
   logic         busy_o;

   int n_cmp = 0;
   int n_bad = 0;

   rv_net_if #(.N_REQ(N)) net ();

   rv_net_arbiter #(.N_REQ(N)) dut (
      .uclock (uclock),
      .reset  (reset),
      .net    (net),
      .hreq_i (hreq_i),
      .hreq_o (hreq_o),
      .gnt_o  (gnt_o),
      .busy_o (busy_o)
   );

   always #5 uclock = ~uclock;

   typedef struct {
      logic       rst;
      logic [1:0] rv;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] hi;
      logic       rdy;
      logic       nv;
      logic [7:0] nd;
      logic [1:0] rr;
      logic       busy;
      logic       gnt;
      logic       hreq;
   } vec_t;

   vec_t        tbl [$];
   logic [7:0]  pkt [300];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [1:0] rv, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] hi, input logic rdy, input logic nv, input logic [7:0] nd,
                      input logic [1:0] rr, input logic busy, input logic gnt, input logic hreq);
      vec_t v;
      v.rst = rst; v.rv = rv; v.d0 = d0; v.d1 = d1; v.hi = hi; v.rdy = rdy;
      v.nv = nv; v.nd = nd; v.rr = rr; v.busy = busy; v.gnt = gnt; v.hreq = hreq;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge uclock);
      reset          = 1'b1;
      net.req_valid  = '0;
      net.req_dat    = '0;
      net.neto_ready = 1'b1;
      hreq_i         = '0;
      @(negedge uclock);
      @(negedge uclock);
      reset = 1'b0;
   endtask

   // Streams pkt[0..n-1] from requester r; stops driving after 'limit' accepted bytes.
   task automatic run_pkt(input int r, input int n, input int limit, input bit rand_rdy,
                          input int gap_at, input int gap_len, input bit oth_v, input string tag);
      int idx      = 0;
      int cyc      = 0;
      int gap_left = gap_len;
      int o        = 1 - r;
      bit in_gap;
      while (idx < limit && cyc < 3000) begin
         @(negedge uclock);
         cyc++;
         net.neto_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         in_gap = (idx == gap_at) && (gap_left > 0);
         net.req_valid[r]       = !in_gap;
         net.req_dat[8*r +: 8]  = pkt[idx];
         net.req_valid[o]       = oth_v;
         net.req_dat[8*o +: 8]  = 8'h55;
         #1;
         if (in_gap) begin
            gap_left--;
            chk({tag, ".gap_busy"}, busy_o, 1'b1);
            chk({tag, ".gap_gnt"}, gnt_o, r[0]);
            chk({tag, ".gap_valid"}, net.neto_valid, 1'b0);
         end
         if (busy_o) begin
            chk({tag, ".gnt"}, gnt_o, r[0]);
            chk({tag, ".other_ready"}, net.req_ready[o], 1'b0);
         end
         if (net.neto_valid && net.neto_ready) begin
            chk($sformatf("%s.byte%0d", tag, idx), net.neto_dat, pkt[idx]);
            idx++;
         end
      end
      chk({tag, ".xfer_count"}, idx, limit);
      if (limit == n) begin
         @(negedge uclock);
         net.req_valid[r] = 1'b0;
         #1;
         chk({tag, ".release_busy"}, busy_o, 1'b0);
         chk({tag, ".release_valid"}, net.neto_valid, 1'b0);
         if (oth_v) begin
            @(negedge uclock);
            #1;
            chk({tag, ".next_gnt"}, gnt_o, o[0]);
            chk({tag, ".next_busy"}, busy_o, 1'b1);
            net.req_valid[o] = 1'b0;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      net.req_valid  = '0;
      net.req_dat    = '0;
      net.neto_ready = 1'b1;

      //   rst rv     d0     d1     hi     rdy   nv  nd     rr     bsy gnt hreq
      add(0, 2'b01, 8'h02, 8'h00, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  0);
      add(0, 2'b01, 8'h02, 8'h00, 2'b00, 1,    1, 8'h02, 2'b01, 1,  0,  1);
      add(0, 2'b01, 8'h01, 8'h00, 2'b00, 1,    1, 8'h01, 2'b01, 1,  0,  1);
      add(0, 2'b01, 8'hAA, 8'h00, 2'b00, 1,    1, 8'hAA, 2'b01, 1,  0,  1);
      add(0, 2'b01, 8'hBB, 8'h00, 2'b00, 1,    1, 8'hBB, 2'b01, 1,  0,  1);
      add(0, 2'b00, 8'h00, 8'h00, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  1);
      add(0, 2'b00, 8'h00, 8'h00, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  0);
      add(1, 2'b00, 8'h00, 8'h00, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  0);
      add(0, 2'b11, 8'h10, 8'h21, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  0);
      add(0, 2'b11, 8'h10, 8'h21, 2'b00, 1,    1, 8'h10, 2'b01, 1,  0,  1);
      add(0, 2'b11, 8'h00, 8'h21, 2'b00, 0,    1, 8'h00, 2'b00, 1,  0,  1);
      add(0, 2'b11, 8'h00, 8'h21, 2'b00, 1,    1, 8'h00, 2'b01, 1,  0,  1);
      add(0, 2'b11, 8'hC0, 8'h21, 2'b00, 1,    1, 8'hC0, 2'b01, 1,  0,  1);
      add(0, 2'b11, 8'h30, 8'h21, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  1);
      add(0, 2'b11, 8'h30, 8'h21, 2'b00, 1,    1, 8'h21, 2'b10, 1,  1,  1);
      add(0, 2'b11, 8'h30, 8'h00, 2'b00, 1,    1, 8'h00, 2'b10, 1,  1,  1);
      add(0, 2'b11, 8'h30, 8'hD1, 2'b00, 1,    1, 8'hD1, 2'b10, 1,  1,  1);
      add(0, 2'b11, 8'h30, 8'h00, 2'b00, 1,    0, 8'h00, 2'b00, 0,  1,  1);
      add(0, 2'b11, 8'h30, 8'h00, 2'b00, 1,    1, 8'h30, 2'b01, 1,  0,  1);
      add(0, 2'b11, 8'h00, 8'h00, 2'b00, 1,    1, 8'h00, 2'b01, 1,  0,  1);
      add(0, 2'b11, 8'hC3, 8'h00, 2'b00, 1,    1, 8'hC3, 2'b01, 1,  0,  1);
      add(0, 2'b00, 8'h00, 8'h00, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  1);
      add(0, 2'b00, 8'h00, 8'h00, 2'b10, 1,    0, 8'h00, 2'b00, 0,  0,  0);
      add(0, 2'b00, 8'h00, 8'h00, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  1);
      add(0, 2'b00, 8'h00, 8'h00, 2'b00, 1,    0, 8'h00, 2'b00, 0,  0,  0);

      do_reset();
      foreach (tbl[k]) begin
         @(negedge uclock);
         reset          = tbl[k].rst;
         net.req_valid  = tbl[k].rv;
         net.req_dat    = {tbl[k].d1, tbl[k].d0};
         hreq_i         = tbl[k].hi;
         net.neto_ready = tbl[k].rdy;
         #1;
         chk($sformatf("v%0d.neto_valid", k), net.neto_valid, tbl[k].nv);
         if (tbl[k].nv) begin
            chk($sformatf("v%0d.neto_dat", k), net.neto_dat, tbl[k].nd);
         end
         chk($sformatf("v%0d.req_ready", k), net.req_ready, tbl[k].rr);
         chk($sformatf("v%0d.busy", k), busy_o, tbl[k].busy);
         chk($sformatf("v%0d.gnt", k), gnt_o, tbl[k].gnt);
         chk($sformatf("v%0d.hreq", k), hreq_o, tbl[k].hreq);
      end

      // Backpressure: SZ=4 packet from req1 under random neto_ready.
      pkt[0] = 8'h05; pkt[1] = 8'h04;
      pkt[2] = 8'h11; pkt[3] = 8'h22; pkt[4] = 8'h33; pkt[5] = 8'h44; pkt[6] = 8'h55;
      run_pkt(1, 7, 7, 1'b1, -1, 0, 1'b0, "bp");

      // Max length: SZ=0xFF from req0, 258 bytes.
      pkt[0] = 8'h01; pkt[1] = 8'hFF;
      for (int i = 0; i < 256; i++) pkt[2+i] = 8'(i) ^ 8'h5A;
      run_pkt(0, 258, 258, 1'b0, -1, 0, 1'b0, "max");

      // Valid gap: req1 drops valid for 5 cycles mid-body while req0 waits.
      pkt[0] = 8'h00; pkt[1] = 8'h03;
      pkt[2] = 8'hA1; pkt[3] = 8'hA2; pkt[4] = 8'hA3; pkt[5] = 8'hA4;
      run_pkt(1, 6, 6, 1'b0, 3, 5, 1'b1, "gap");

      // Reset in the middle of a req1 body.
      do_reset();
      pkt[0] = 8'h09; pkt[1] = 8'h05;
      for (int i = 0; i < 6; i++) pkt[2+i] = 8'(i + 1);
      run_pkt(1, 8, 4, 1'b0, -1, 0, 1'b0, "rst_pre");
      chk("rst_pre.gnt", gnt_o, 1'b1);
      @(negedge uclock);
      reset         = 1'b1;
      net.req_valid = 2'b11;
      net.req_dat   = {8'h03, 8'h66};
      @(negedge uclock);
      reset = 1'b0;
      #1;
      chk("rst.busy", busy_o, 1'b0);
      chk("rst.neto_valid", net.neto_valid, 1'b0);
      chk("rst.hreq", hreq_o, 1'b0);
      chk("rst.gnt", gnt_o, 1'b0);
      chk("rst.req_ready", net.req_ready, 2'b00);
      @(negedge uclock);
      #1;
      chk("rst.first_gnt", gnt_o, 1'b0);
      chk("rst.first_busy", busy_o, 1'b1);
      chk("rst.first_valid", net.neto_valid, 1'b1);
      chk("rst.first_dat", net.neto_dat, 8'h66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rv_net_arbiter.md
Name: rv_net_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one 8-bit ready/valid message-net output between N_REQ endpoint/BFM initiators, such as multiple tblink RPC endpoints on one net segment.
- Parses the net header so a grant is held for exactly one whole packet.
- Aggregates the host-request (hreq) chain for its requesters.
- Sits between the endpoint `neto_` outputs and the upstream net link.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..8.
- GNT_W, $clog2(N_REQ), width of the grant index; derived localparam, not to be overridden.

Ports:
- uclock  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester byte valid
- req_ready  output  N_REQ  per-requester byte ready
- req_dat  input  8*N_REQ  per-requester byte; requester i occupies [8*i+7:8*i]
- neto_valid  output  1  merged byte valid
- neto_ready  input  1  merged byte ready
- neto_dat  output  8  merged byte
- hreq_i  input  N_REQ  per-requester host request
- hreq_o  output  1  aggregated host request, registered
- gnt_o  output  GNT_W  current grant index; debug only
- busy_o  output  1  packet in flight

Behaviour:
- Interface (already decided): one clock, uclock; reset is synchronous and active-high, named reset.
- Packet format: byte0 DST, byte1 SZ, then SZ+1 body bytes. Total length is SZ+3 bytes; SZ=255 gives 256 body bytes.
- FSM states: IDLE, DST, SZ, BODY.
- Reset values:
  - state=IDLE, gnt=0, last=N_REQ-1, so requester 0 wins first.
  - rem=0, hreq_o=0.
  - neto_valid=0, req_ready=0, busy_o=0.
- IDLE: when any req_valid is set, pick the first i with req_valid[i] set, searching from last+1 (mod N_REQ) upward. Register gnt=i and move to DST. No byte transfers in IDLE.
- Latency: first byte can transfer one cycle after req_valid rises in IDLE.
- Outside IDLE:
  - neto_valid = req_valid[gnt]
  - neto_dat = req_dat[gnt]
  - req_ready[gnt] = neto_ready; all other req_ready bits = 0
  - busy_o = 1
- Transitions (a transfer is neto_valid && neto_ready):
  - DST: on transfer, go to SZ.
  - SZ: on transfer, rem <= neto_dat; go to BODY.
  - BODY: on transfer, if rem==0 then last <= gnt and go to IDLE; else rem <= rem-1.
- Grant lock: the grant is held for the whole packet even if req_valid[gnt] drops mid-packet. No other requester is served and there is no timeout.
- Back-to-back packets: one IDLE bubble cycle between packets. A requester that just finished has lowest priority in the next pick.
- Fairness: with all requesters valid continuously, grants rotate 0,1,...,N_REQ-1,0,...
- hreq_o <= |hreq_i | |req_valid | (state!=IDLE), registered on uclock.
- Reset mid-packet: immediate return to IDLE with the reset values above. The partial packet is dropped and recovery is the system's responsibility.
- neto_ready low in any state: hold state; no counter change.

Optional Feature:
- Macro: RV_NET_ARB_OUTREG_EN.
- Defined:
  - neto_valid/neto_dat driven from a 2-entry skid buffer. Full throughput; +1 cycle latency.
  - req_ready[gnt] = buffer not full.
  - FSM counts transfers on the requester side (req_valid[gnt] && req_ready[gnt]). Release to IDLE is independent of buffer drain.
  - Reset empties the buffer.
- Undefined: purely combinational forward path as described in Behaviour.

Decomposition:
- Package rv_net_pkg:
  - FSM state encoding (IDLE=2'b00, DST=2'b01, SZ=2'b10, BODY=2'b11)
  - header byte offsets HDR_DST=0, HDR_SZ=1
  - NET_DAT_W=8
- One sub-module, rv_rr_pick: combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: found flag, grant index.
  - Reused by later net switches.

Test Plan:
- Single packet: req0 sends DST=0x02, SZ=0x01, body 0xAA,0xBB with neto_ready=1. Required: 4 neto transfers in order; busy_o falls after 0xBB; req_ready[1]=0 throughout.
- Contention: req0 and req1 valid from the same cycle, each with a packet of SZ=0. Required: req0's 3 bytes, one bubble, then req1's 3 bytes, with no interleaving; the third packet goes to req0 again.
- Backpressure: randomly toggle neto_ready 50% on an SZ=4 packet. Required: exactly 7 bytes, unchanged order, rem decrements only on transfers.
- Max length: SZ=0xFF. Required: 258 transfers, then IDLE; no wrap or early release.
- Valid gap: req1 drops valid for 5 cycles mid-body while req0 is valid. Required: gnt_o stays 1; req0 is not granted until req1's packet completes.
- Reset mid-BODY: assert reset for 1 cycle. Required: next cycle IDLE, neto_valid=0, hreq_o=0, gnt_o=0; the first grant after reset goes to req0.
